// File: rtl/inst_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_arb_pkg
// Shared definitions for the instruction-memory arbiter: bus widths, the
// all-zero word, ROM chip-enable encodings and the read-owner state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_mem_arb_pkg;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;

    localparam logic [InstBusW-1:0] ZeroWord    = '0;
    localparam logic                ChipEnable  = 1'b1;
    localparam logic                ChipDisable = 1'b0;

    // Owner of the read currently in flight (granted in the previous cycle).
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_IF   = 2'b01,
        S_DBG  = 2'b10
    } owner_e;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_mem_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Counts consecutive cycles a low-priority requester has been waiting and
// refused. Saturates at LIMIT; at_limit_o tells the arbiter to let it win.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (counter to 0)
//   wait_i     - requester is asking this cycle
//   served_i   - requester is granted this cycle
//   at_limit_o - counter has reached LIMIT
// -----------------------------------------------------------------------------
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    input  logic served_i,
    output logic at_limit_o
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == LIMIT_C);

    // A grant or a withdrawn request ends the waiting streak.
    always_comb begin
        cnt_d = cnt_q;
        if (served_i || !wait_i) begin
            cnt_d = '0;
        end else if (!at_limit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_mem_arb.sv
// -----------------------------------------------------------------------------
// inst_mem_arb
// Arbitrates a single combinational instruction ROM between the fetch stage
// and a debug/loader port. Fetch has priority; a waiting debug request is
// guaranteed to win after STARVE_LIMIT consecutive refusals. Reads complete
// with a fixed one-cycle latency and may issue back to back.
//
// Ports:
//   clk, rst                  - clock (rising edge), async active-high reset
//   if_req/if_addr            - fetch request (level) and byte address
//   if_gnt                    - fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata        - fetch read result, rvalid is a 1-cycle pulse
//   dbg_*                     - same set for the debug/loader port
//   stallreq                  - fetch is requesting but not granted
//   addr_err                  - pulses with rvalid of a misaligned read
//   rom_ce/rom_addr/rom_inst  - ROM chip enable, word address, read data
// -----------------------------------------------------------------------------
module inst_mem_arb
    import inst_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [InstAddrBusW-1:0] if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [InstBusW-1:0]     if_rdata,

    input  logic                    dbg_req,
    input  logic [InstAddrBusW-1:0] dbg_addr,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [InstBusW-1:0]     dbg_rdata,

    output logic                    stallreq,
    output logic                    addr_err,

    output logic                    rom_ce,
    output logic [InstAddrBusW-1:0] rom_addr,
    input  logic [InstBusW-1:0]     rom_inst
);

    owner_e              state_q;
    owner_e              state_d;
    logic [InstBusW-1:0] if_rdata_q;
    logic [InstBusW-1:0] if_rdata_d;
    logic [InstBusW-1:0] dbg_rdata_q;
    logic [InstBusW-1:0] dbg_rdata_d;
    logic                addr_err_q;
    logic                addr_err_d;
    logic                dbg_at_limit;

    arb_starve_cnt #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .wait_i     (dbg_req),
        .served_i   (dbg_gnt),
        .at_limit_o (dbg_at_limit)
    );

    // Grant, ROM drive and next owner. Everything is forced quiet while rst
    // is high so nothing reaches the ROM or the pipeline during reset.
    always_comb begin
        if_gnt   = 1'b0;
        dbg_gnt  = 1'b0;
        state_d  = S_IDLE;
        rom_ce   = ChipDisable;
        rom_addr = ZeroWord;
        stallreq = 1'b0;

        if (!rst) begin
            if (dbg_req && (!if_req || dbg_at_limit)) begin
                dbg_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
            stallreq = if_req && !if_gnt;
        end

        // Byte offset is dropped so a misaligned request still reads the
        // word that contains it.
        if (dbg_gnt) begin
            state_d  = S_DBG;
            rom_ce   = ChipEnable;
            rom_addr = {dbg_addr[InstAddrBusW-1:2], 2'b00};
        end else if (if_gnt) begin
            state_d  = S_IF;
            rom_ce   = ChipEnable;
            rom_addr = {if_addr[InstAddrBusW-1:2], 2'b00};
        end
    end

    // ROM data is captured at the edge that ends the grant cycle; each port's
    // data register holds between its own reads.
    always_comb begin
        if_rdata_d  = if_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        addr_err_d  = 1'b0;
        if (if_gnt) begin
            if_rdata_d = rom_inst;
            addr_err_d = addr_misaligned(if_addr[1:0]);
        end
        if (dbg_gnt) begin
            dbg_rdata_d = rom_inst;
            addr_err_d  = addr_misaligned(dbg_addr[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            if_rdata_q  <= ZeroWord;
            dbg_rdata_q <= ZeroWord;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_rdata_q  <= if_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // The owner state doubles as the rvalid source: a read is valid for
    // exactly the cycle after its grant.
    assign if_rvalid  = (state_q == S_IF);
    assign dbg_rvalid = (state_q == S_DBG);
    assign if_rdata   = if_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_inst_mem_arb.sv
module tb_inst_mem_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        stallreq;
    logic        addr_err;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    int checks;
    int errors;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic [31:0] da;
        logic        eig;
        logic        edg;
    } vec_t;

    typedef struct {
        logic        port;   // 0 = fetch, 1 = debug
        logic [31:0] data;
        logic        err;
    } rd_t;

    vec_t        vecs[$];
    rd_t         sb[$];
    logic [31:0] last_if;
    logic [31:0] last_dbg;

    inst_mem_arb #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .stallreq   (stallreq),
        .addr_err   (addr_err),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        if (idx == 30'd1) return 32'h34011100;
        return {2'b10, idx} ^ 32'h5A5A0000;
    endfunction

    // ROM model: combinational, word indexed
    always_comb rom_inst = rom_word(rom_addr[31:2]);

    function automatic vec_t mk(input logic ifr, input logic [31:0] ifa,
                                input logic dr, input logic [31:0] da,
                                input logic eig, input logic edg);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.da = da; v.eig = eig; v.edg = edg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at ~1 time unit after a rising edge.
    task automatic step(input vec_t v);
        rd_t r;
        if_req   = v.ifr;
        if_addr  = v.ifa;
        dbg_req  = v.dr;
        dbg_addr = v.da;
        #1;
        check("if_gnt",   {31'b0, if_gnt},   {31'b0, v.eig});
        check("dbg_gnt",  {31'b0, dbg_gnt},  {31'b0, v.edg});
        check("stallreq", {31'b0, stallreq}, {31'b0, v.ifr && !v.eig});
        check("rom_ce",   {31'b0, rom_ce},   {31'b0, v.eig || v.edg});
        if (v.edg)      check("rom_addr", rom_addr, {v.da[31:2], 2'b00});
        else if (v.eig) check("rom_addr", rom_addr, {v.ifa[31:2], 2'b00});
        else            check("rom_addr", rom_addr, 32'h0);
        if (v.eig) begin
            r.port = 1'b0; r.data = rom_word(v.ifa[31:2]); r.err = (v.ifa[1:0] != 2'b00);
            sb.push_back(r);
        end else if (v.edg) begin
            r.port = 1'b1; r.data = rom_word(v.da[31:2]); r.err = (v.da[1:0] != 2'b00);
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.port) last_dbg = r.data;
            else        last_if  = r.data;
            check("if_rvalid",  {31'b0, if_rvalid},  {31'b0, !r.port});
            check("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, r.port});
            check("addr_err",   {31'b0, addr_err},   {31'b0, r.err});
        end else begin
            check("if_rvalid_idle",  {31'b0, if_rvalid},  32'h0);
            check("dbg_rvalid_idle", {31'b0, dbg_rvalid}, 32'h0);
            check("addr_err_idle",   {31'b0, addr_err},   32'h0);
        end
        check("if_rdata",  if_rdata,  last_if);
        check("dbg_rdata", dbg_rdata, last_dbg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_gnt"},     {31'b0, if_gnt},     32'h0);
        check({tag, "_dbg_gnt"},    {31'b0, dbg_gnt},    32'h0);
        check({tag, "_rom_ce"},     {31'b0, rom_ce},     32'h0);
        check({tag, "_stallreq"},   {31'b0, stallreq},   32'h0);
        check({tag, "_if_rvalid"},  {31'b0, if_rvalid},  32'h0);
        check({tag, "_dbg_rvalid"}, {31'b0, dbg_rvalid}, 32'h0);
        check({tag, "_if_rdata"},   if_rdata,            32'h0);
        check({tag, "_dbg_rdata"},  dbg_rdata,           32'h0);
        check({tag, "_addr_err"},   {31'b0, addr_err},   32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        last_if  = 32'h0;
        last_dbg = 32'h0;

        // Single fetch, then idle
        vecs.push_back(mk(1, 32'h4, 0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0));
        // Both requesting continuously: 4 fetch grants then 1 debug grant
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1, 32'h100 + 32'(4 * k), 1, 32'h200 + 32'(4 * k),
                              (k % 5) != 4, (k % 5) == 4));
        // Alternating single requests
        vecs.push_back(mk(1, 32'h10, 0, 32'h0,  1, 0));
        vecs.push_back(mk(0, 32'h0,  1, 32'h14, 0, 1));
        vecs.push_back(mk(1, 32'h18, 0, 32'h0,  1, 0));
        vecs.push_back(mk(0, 32'h0,  1, 32'h1C, 0, 1));
        // Misaligned reads on both ports
        vecs.push_back(mk(0, 32'h0, 1, 32'h6, 0, 1));
        vecs.push_back(mk(1, 32'h9, 0, 32'h0, 1, 0));
        // Debug waits 3 cycles, drops, reasserts: waits 4 more then wins
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 32'h20, 1, 32'h80, 1, 0));
        vecs.push_back(mk(1, 32'h24, 0, 32'h80, 1, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 32'h28 + 32'(4 * k), 1, 32'h84, 1, 0));
        vecs.push_back(mk(1, 32'h38, 1, 32'h84, 0, 1));
        vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0));

        // Reset with both requests asserted: everything quiet
        rst      = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h4;
        dbg_req  = 1'b1;
        dbg_addr = 32'h8;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        if_req  = 1'b0;
        dbg_req = 1'b0;
        rst     = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Reset asserted right as the grant cycle ends: the read is dropped
        if_req  = 1'b1;
        if_addr = 32'h5;
        dbg_req = 1'b0;
        #1;
        check("mid_rst_if_gnt", {31'b0, if_gnt}, 32'h1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        last_if  = 32'h0;
        last_dbg = 32'h0;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("hold_rst");
        if_req = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_if_rvalid",  {31'b0, if_rvalid},  32'h0);
        check("post_rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);

        // Recovery after reset
        step(mk(0, 32'h0, 1, 32'h4, 0, 1));
        step(mk(1, 32'hC, 0, 32'h0, 1, 0));
        step(mk(0, 32'h0, 0, 32'h0, 0, 0));

        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
